// File: rtl/sfifo_rr_drain_pkg.sv
// ---------------------------------------------------------------------------
// sfifo_rr_drain_pkg
//
// Purpose: shared types and helpers for the sfifo_rr_drain slice. It holds
// the lock FSM state encoding, the default channel count and word width, the
// channel-index width helper, and the EOP bit position helper.
//
// Contents:
//   drainState_e : IDLE (0) = arbitrating, LOCKED (1) = inside a packet
//   DEF_NCH      : default number of input channels
//   DEF_WIDTH    : default word width (MSB is the EOP flag)
//   chanBits()   : width of a channel index, clog2(n) with a floor of 1
//   eopBit()     : bit position of the EOP flag inside a word
// ---------------------------------------------------------------------------
package sfifo_rr_drain_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } drainState_e;

  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 16;

  // A single channel still needs a 1-bit index so port widths never collapse.
  function automatic int chanBits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int eopBit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/sfifo_rr_drain_if.sv
// ---------------------------------------------------------------------------
// sfifo_rr_drain_if
//
// Purpose: bundles the upstream FIFO-array signals and the downstream
// valid/ready output of the drain stage into one interface.
//
// Signals:
//   fifo_empty [NCH]        per-channel empty flag from the 1-deep FIFOs
//   fifo_dout  [NCH*WIDTH]  per-channel head word, channel i at [i*WIDTH +: WIDTH]
//   fifo_rd    [NCH]        per-channel pop strobe (one-hot or zero)
//   out_valid               output register holds a word
//   out_data   [WIDTH]      forwarded word, EOP in the MSB
//   out_src    [NCH_BITS]   channel the forwarded word came from
//   out_ready               downstream accepts the word this cycle
//
// Modports:
//   master : the drain stage (drives fifo_rd and the out_* register)
//   slave  : the environment (FIFO array plus downstream consumer)
// ---------------------------------------------------------------------------
interface sfifo_rr_drain_if
  import sfifo_rr_drain_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NCH_BITS = chanBits(NCH)
);

  logic [NCH-1:0]       fifo_empty;
  logic [NCH*WIDTH-1:0] fifo_dout;
  logic [NCH-1:0]       fifo_rd;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [NCH_BITS-1:0]  out_src;
  logic                 out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd, out_valid, out_data, out_src
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd, out_valid, out_data, out_src
  );

endinterface

// File: rtl/sfifo_rr_drain_rr_pick.sv
// ---------------------------------------------------------------------------
// sfifo_rr_drain_rr_pick
//
// Purpose: purely combinational rotate-priority picker. Starting at i_ptr
// and wrapping from NCH-1 back to 0, it returns the first requesting index.
// Nothing here is specific to the drain stage, so other arbiters can reuse it.
//
// Ports:
//   i_req   [NCH]       request vector, bit i = requester i wants service
//   i_ptr   [NCH_BITS]  highest-priority index for this pick (< NCH)
//   o_grant [NCH_BITS]  chosen index (0 when nothing requests)
//   o_valid             at least one request was present
// ---------------------------------------------------------------------------
module sfifo_rr_drain_rr_pick #(
  parameter int NCH      = 4,
  parameter int NCH_BITS = 2
) (
  input  logic [NCH-1:0]      i_req,
  input  logic [NCH_BITS-1:0] i_ptr,
  output logic [NCH_BITS-1:0] o_grant,
  output logic                o_valid
);

  logic [2*NCH-1:0]  w_reqDouble;
  logic [NCH-1:0]    w_reqRotated;
  logic [NCH_BITS:0] w_sum;

  // Doubling the request vector turns the wrap-around search into a plain
  // right shift: bit k of the rotated vector is requester (i_ptr + k) mod NCH.
  assign w_reqDouble  = {i_req, i_req};
  assign w_reqRotated = NCH'(w_reqDouble >> i_ptr);

  // Walk the offsets from the far end down to 0 so the smallest offset, the
  // one closest to the pointer, is the last writer and therefore wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_reqRotated[k]) begin
        w_sum = {1'b0, i_ptr} + (NCH_BITS + 1)'(k);
        if (w_sum >= (NCH_BITS + 1)'(NCH)) begin
          w_sum = w_sum - (NCH_BITS + 1)'(NCH);
        end
        o_grant = w_sum[NCH_BITS-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfifo_rr_drain.sv
// ---------------------------------------------------------------------------
// sfifo_rr_drain
//
// Purpose: packet-aware round-robin drain stage for an array of 1-deep
// FIFOs. It pops one word per cycle from a chosen channel and forwards it
// through a single registered valid/ready output, tagged with its source
// channel. Once a channel wins, the grant stays locked to it until the
// packet's EOP word (MSB set) has been popped, and then the round-robin
// pointer moves to the next channel.
//
// Ports:
//   clk   single clock, every state update on its rising edge
//   rst   synchronous, active-high reset
//   bus   sfifo_rr_drain_if.master
//           fifo_empty / fifo_dout in,  fifo_rd out (combinational)
//           out_valid / out_data / out_src out (registered), out_ready in
// ---------------------------------------------------------------------------
module sfifo_rr_drain
  import sfifo_rr_drain_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NCH_BITS = chanBits(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  sfifo_rr_drain_if.master bus
);

  localparam int                  EOP_POS = eopBit(WIDTH);
  localparam logic [NCH_BITS-1:0] LAST_CH = NCH_BITS'(NCH - 1);

  drainState_e         r_state;
  drainState_e         w_stateNext;
  logic [NCH_BITS-1:0] r_lockCh;
  logic [NCH_BITS-1:0] w_lockChNext;
  logic [NCH_BITS-1:0] r_rrPtr;
  logic [NCH_BITS-1:0] w_rrPtrNext;

  logic                r_outValid;
  logic [WIDTH-1:0]    r_outData;
  logic [NCH_BITS-1:0] r_outSrc;

  logic                w_slotFree;
  logic                w_pickValid;
  logic [NCH_BITS-1:0] w_pickCh;
  logic                w_pop;
  logic [NCH_BITS-1:0] w_popCh;
  logic [WIDTH-1:0]    w_popWord;
  logic                w_popEop;
  logic [NCH-1:0]      w_rd;
  logic [WIDTH-1:0]    w_chWord [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_chWord
    assign w_chWord[g] = bus.fifo_dout[g*WIDTH +: WIDTH];
  end

  // The output register can take a new word when it is empty or when its
  // current word leaves this cycle; this is the direct out_ready -> fifo_rd path.
  assign w_slotFree = ~r_outValid | bus.out_ready;

  sfifo_rr_drain_rr_pick #(
    .NCH      (NCH),
    .NCH_BITS (NCH_BITS)
  ) u_rrPick (
    .i_req   (~bus.fifo_empty),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickCh),
    .o_valid (w_pickValid)
  );

  // Pop decision. While idle the picker's choice is used; while locked only
  // the locked channel is looked at, so other channels cannot sneak in
  // mid-packet. Reset gates every pop strobe.
  always_comb begin
    w_pop   = 1'b0;
    w_popCh = r_lockCh;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_slotFree && w_pickValid) begin
            w_pop   = 1'b1;
            w_popCh = w_pickCh;
          end
        end
        LOCKED: begin
          if (w_slotFree && !bus.fifo_empty[r_lockCh]) begin
            w_pop = 1'b1;
          end
        end
        default: begin
          w_pop = 1'b0;
        end
      endcase
    end
  end

  assign w_popWord = w_chWord[w_popCh];
  assign w_popEop  = w_popWord[EOP_POS];

  always_comb begin
    w_rd = '0;
    if (w_pop) begin
      w_rd[w_popCh] = 1'b1;
    end
  end

  assign bus.fifo_rd = w_rd;

  // Lock FSM next state. An EOP pop always ends up in IDLE with the pointer
  // just past the channel that finished, whether the packet was a single
  // word (never locked) or a multi-word one; in LOCKED w_popCh == r_lockCh.
  always_comb begin
    w_stateNext  = r_state;
    w_lockChNext = r_lockCh;
    w_rrPtrNext  = r_rrPtr;
    if (w_pop) begin
      if (w_popEop) begin
        w_stateNext = IDLE;
        w_rrPtrNext = (w_popCh == LAST_CH) ? '0 : w_popCh + 1'b1;
      end else if (r_state == IDLE) begin
        w_stateNext  = LOCKED;
        w_lockChNext = w_popCh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lockCh <= '0;
      r_rrPtr  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_lockCh <= w_lockChNext;
      r_rrPtr  <= w_rrPtrNext;
    end
  end

  // Output register: a pop always reloads it (back-to-back when out_ready is
  // high); without a pop, an accepted word empties it and a stalled word is
  // held untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= '0;
    end else if (w_pop) begin
      r_outValid <= 1'b1;
      r_outData  <= w_popWord;
      r_outSrc   <= w_popCh;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_src   = r_outSrc;

endmodule

// File: tb/tb_sfifo_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_sfifo_rr_drain
//
// Self-checking bench for sfifo_rr_drain. Each channel is a word list that
// stands in for the upstream FIFO; a channel reads as empty when its list is
// exhausted or when hideMask forces it empty. Words encode {eop, ch, seq}
// so every expected output can be written down by hand.
// ---------------------------------------------------------------------------
module tb_sfifo_rr_drain;

  localparam int NCH      = 4;
  localparam int WIDTH    = 16;
  localparam int NCH_BITS = 2;
  localparam int DEPTH    = 4096;

  logic clk;
  logic rst;

  sfifo_rr_drain_if #(.NCH(NCH), .WIDTH(WIDTH), .NCH_BITS(NCH_BITS)) bus ();

  sfifo_rr_drain #(.NCH(NCH), .WIDTH(WIDTH), .NCH_BITS(NCH_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] srcMem [NCH][DEPTH];
  int               head    [NCH];
  int               tail    [NCH];
  int               expHead [NCH];
  logic [NCH-1:0]   hideMask;
  logic [NCH-1:0]   rdSeen;
  logic [NCH-1:0]   emptySeen;
  int               openCh;
  int               checkCount;
  int               errorCount;

  function automatic logic [WIDTH-1:0] mkWord(input logic eop, input int ch, input int seq);
    return {eop, 3'b000, 4'(ch), 8'(seq)};
  endfunction

  task automatic pushWord(input int ch, input logic eop);
    srcMem[ch][tail[ch]] = mkWord(eop, ch, tail[ch]);
    tail[ch]++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic v, input int src,
                           input logic [WIDTH-1:0] data);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      checkOutput({tag, ".src"}, 32'(bus.out_src), 32'(src));
      checkOutput({tag, ".data"}, 32'(bus.out_data), 32'(data));
    end
  endtask

  // One clock cycle: drive the FIFO view and out_ready at the falling edge,
  // look at the pop strobes once they settle, account for the handshake and
  // the pops, then step past the rising edge so outputs can be examined.
  task automatic applyStimulus(input logic ready);
    int s;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      bus.fifo_empty[i] = (head[i] == tail[i]) || hideMask[i];
      bus.fifo_dout[i*WIDTH +: WIDTH] = srcMem[i][head[i]];
    end
    bus.out_ready = ready;
    #1;
    rdSeen    = bus.fifo_rd;
    emptySeen = bus.fifo_empty;
    checkOutput("rdOnEmpty", 32'(rdSeen & emptySeen), 32'd0);
    checkOutput("rdOneHot", 32'($countones(rdSeen) <= 1), 32'd1);
    if (rst) begin
      checkOutput("rdInReset", 32'(rdSeen), 32'd0);
    end
    if (bus.out_valid && ready) begin
      s = int'(bus.out_src);
      if (expHead[s] < tail[s]) begin
        checkOutput("order", 32'(bus.out_data), 32'(srcMem[s][expHead[s]]));
        expHead[s]++;
      end else begin
        checkOutput("orderOverrun", 32'(expHead[s]), 32'(tail[s] - 1));
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (rdSeen[c] && head[c] < tail[c]) begin
        if (openCh >= 0) begin
          checkOutput("interleave", 32'(c), 32'(openCh));
        end
        openCh = srcMem[c][head[c]][WIDTH-1] ? -1 : c;
        head[c]++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      openCh = -1;
    end
  endtask

  initial begin
    bit done;
    int len;
    int budget;
    checkCount     = 0;
    errorCount     = 0;
    openCh         = -1;
    hideMask       = '0;
    rst            = 1'b1;
    bus.out_ready  = 1'b0;
    bus.fifo_empty = '1;
    bus.fifo_dout  = '0;
    for (int c = 0; c < NCH; c++) begin
      head[c]    = 0;
      tail[c]    = 0;
      expHead[c] = 0;
    end

    $display("[TB] reset");
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("resetValid", 32'(bus.out_valid), 32'd0);
    checkOutput("resetData", 32'(bus.out_data), 32'd0);
    checkOutput("resetSrc", 32'(bus.out_src), 32'd0);
    rst = 1'b0;

    $display("[TB] single-word packets rotate 0,1,2,3 then wrap");
    for (int c = 0; c < NCH; c++) pushWord(c, 1'b1);
    for (int c = 0; c < NCH; c++) begin
      applyStimulus(1'b1);
      expectOut("rr", 1'b1, c, mkWord(1'b1, c, 0));
    end
    pushWord(2, 1'b1);
    pushWord(0, 1'b1);
    applyStimulus(1'b1);
    expectOut("wrap0", 1'b1, 0, mkWord(1'b1, 0, 1));
    applyStimulus(1'b1);
    expectOut("wrap2", 1'b1, 2, mkWord(1'b1, 2, 1));
    applyStimulus(1'b1);
    expectOut("idle1", 1'b0, 0, '0);

    $display("[TB] 3-word packet on channel 2 with competitors ready");
    pushWord(1, 1'b1);
    applyStimulus(1'b1);
    expectOut("ptrTo2", 1'b1, 1, mkWord(1'b1, 1, 1));
    pushWord(2, 1'b0);
    pushWord(2, 1'b0);
    pushWord(2, 1'b1);
    pushWord(0, 1'b1);
    pushWord(1, 1'b1);
    pushWord(3, 1'b1);
    applyStimulus(1'b1);
    expectOut("pkt2w1", 1'b1, 2, mkWord(1'b0, 2, 2));
    applyStimulus(1'b1);
    expectOut("pkt2w2", 1'b1, 2, mkWord(1'b0, 2, 3));
    applyStimulus(1'b1);
    expectOut("pkt2w3", 1'b1, 2, mkWord(1'b1, 2, 4));
    applyStimulus(1'b1);
    expectOut("after2", 1'b1, 3, mkWord(1'b1, 3, 1));
    applyStimulus(1'b1);
    expectOut("next0", 1'b1, 0, mkWord(1'b1, 0, 2));
    applyStimulus(1'b1);
    expectOut("next1", 1'b1, 1, mkWord(1'b1, 1, 2));
    applyStimulus(1'b1);
    expectOut("idle2", 1'b0, 0, '0);

    $display("[TB] locked channel 1 runs dry for 5 cycles");
    pushWord(0, 1'b1);
    applyStimulus(1'b1);
    expectOut("ptrTo1", 1'b1, 0, mkWord(1'b1, 0, 3));
    pushWord(1, 1'b0);
    pushWord(0, 1'b1);
    pushWord(2, 1'b1);
    pushWord(3, 1'b1);
    applyStimulus(1'b1);
    expectOut("lock1", 1'b1, 1, mkWord(1'b0, 1, 3));
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1);
      checkOutput("gapRd", 32'(rdSeen), 32'd0);
      expectOut("gapOut", 1'b0, 0, '0);
    end
    pushWord(1, 1'b1);
    applyStimulus(1'b1);
    expectOut("resume1", 1'b1, 1, mkWord(1'b1, 1, 4));
    applyStimulus(1'b1);
    expectOut("then2", 1'b1, 2, mkWord(1'b1, 2, 5));
    applyStimulus(1'b1);
    expectOut("then3", 1'b1, 3, mkWord(1'b1, 3, 2));
    applyStimulus(1'b1);
    expectOut("then0", 1'b1, 0, mkWord(1'b1, 0, 4));
    applyStimulus(1'b1);
    expectOut("idle3", 1'b0, 0, '0);

    $display("[TB] backpressure holds the output register");
    pushWord(1, 1'b1);
    pushWord(2, 1'b1);
    applyStimulus(1'b1);
    expectOut("preHold", 1'b1, 1, mkWord(1'b1, 1, 5));
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0);
      checkOutput("holdRd", 32'(rdSeen), 32'd0);
      expectOut("hold", 1'b1, 1, mkWord(1'b1, 1, 5));
    end
    applyStimulus(1'b1);
    expectOut("release", 1'b1, 2, mkWord(1'b1, 2, 6));
    applyStimulus(1'b1);
    expectOut("idle4", 1'b0, 0, '0);

    $display("[TB] reset while locked on channel 3");
    pushWord(3, 1'b0);
    pushWord(3, 1'b0);
    pushWord(3, 1'b1);
    pushWord(0, 1'b1);
    pushWord(1, 1'b1);
    pushWord(2, 1'b1);
    applyStimulus(1'b1);
    expectOut("lock3", 1'b1, 3, mkWord(1'b0, 3, 3));
    rst = 1'b1;
    applyStimulus(1'b1);
    rst = 1'b0;
    checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstData", 32'(bus.out_data), 32'd0);
    checkOutput("rstSrc", 32'(bus.out_src), 32'd0);
    applyStimulus(1'b1);
    expectOut("postRst0", 1'b1, 0, mkWord(1'b1, 0, 5));
    applyStimulus(1'b1);
    expectOut("postRst1", 1'b1, 1, mkWord(1'b1, 1, 6));
    applyStimulus(1'b1);
    expectOut("postRst2", 1'b1, 2, mkWord(1'b1, 2, 7));
    applyStimulus(1'b1);
    expectOut("postRst3a", 1'b1, 3, mkWord(1'b0, 3, 4));
    applyStimulus(1'b1);
    expectOut("postRst3b", 1'b1, 3, mkWord(1'b1, 3, 5));
    applyStimulus(1'b1);
    expectOut("idle5", 1'b0, 0, '0);

    $display("[TB] random empties and backpressure");
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (head[c] == tail[c] && tail[c] < DEPTH - 4) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) pushWord(c, k == len - 1);
        end
      end
      hideMask = 4'($urandom);
      applyStimulus(1'($urandom_range(0, 1)));
    end

    hideMask = '0;
    done     = 1'b0;
    budget   = 0;
    while (!done && budget < 300) begin
      applyStimulus(1'b1);
      budget++;
      done = !bus.out_valid;
      for (int c = 0; c < NCH; c++) begin
        if (head[c] != tail[c]) done = 1'b0;
      end
    end
    checkOutput("drainDone", 32'(done), 32'd1);
    for (int c = 0; c < NCH; c++) begin
      checkOutput("drainCh", 32'(expHead[c]), 32'(tail[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
